// File: rtl/flash_pkg.sv
// Shared constants and FSM state type for the flash command responder.
package flash_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_U1, S_U2, S_PGM, S_E1, S_E2, S_E3, S_BUSY_P, S_BUSY_E
  } state_t;

  localparam logic [7:0] CMD_UNLOCK1 = 8'hAA;
  localparam logic [7:0] CMD_UNLOCK2 = 8'h55;
  localparam logic [7:0] CMD_PROG    = 8'hA0;
  localparam logic [7:0] CMD_ERASE   = 8'h80;
  localparam logic [7:0] CMD_CHIP    = 8'h10;
  localparam logic [7:0] CMD_SECT    = 8'h30;
  localparam logic [7:0] CMD_ID      = 8'h90;
  localparam logic [7:0] CMD_EXIT    = 8'hF0;

  localparam logic [15:0] ADDR_5555 = 16'h5555;
  localparam logic [15:0] ADDR_AAAA = 16'hAAAA;

  function automatic logic cmd_hit(input logic [15:0] a, input logic [7:0] d,
                                   input logic [15:0] ea, input logic [7:0] ed);
    return (a == ea) && (d == ed);
  endfunction

endpackage

// File: rtl/flash_array.sv
// 64K x 8 synchronous flash storage: one write port, one registered read port, no reset.
module flash_array (
  input  logic        clk,
  input  logic        we,
  input  logic [15:0] waddr,
  input  logic [7:0]  wdata,
  input  logic        re,
  input  logic [15:0] raddr,
  output logic [7:0]  rdata
);

  logic [7:0] mem [0:65535];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/flash_cmd_responder.sv
// JEDEC-style flash command responder: unlock decode, program/erase, busy polling.
// Optional software-ID mode is enabled by defining FLASH_SOFTWARE_ID_EN.
module flash_cmd_responder
  import flash_pkg::*;
#(
  parameter int         PROG_CYCLES = 20,
  parameter logic [7:0] MFG_ID      = 8'hBF,
  parameter logic [7:0] DEV_ID      = 8'hB5,
  parameter int         SECTOR_BITS = 12
) (
  input  logic        SCL,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic [7:0]  DataIn,
  input  logic        WE,
  input  logic        RE,
  output logic [7:0]  DataOut,
  output logic        Busy
);

  localparam logic [15:0] PROG_LAST = 16'(PROG_CYCLES - 1);
  localparam logic [15:0] SECT_MASK = 16'((1 << SECTOR_BITS) - 1);

  state_t      state;
  logic [15:0] cnt, erase_base, erase_last, prog_addr;
  logic [7:0]  prog_data, reg_q, arr_q;
  logic        pollbit, toggle, sel_arr, id_flag;
  logic        rd, pgm_acc, chip_acc, sect_acc, busy_start, prog_done, erase_done;

  assign Busy       = (state == S_BUSY_P) || (state == S_BUSY_E);
  assign rd         = RE && !WE;
  assign pgm_acc    = WE && (state == S_PGM);
  assign chip_acc   = WE && (state == S_E3) && cmd_hit(Addr, DataIn, ADDR_5555, CMD_CHIP);
  assign sect_acc   = WE && (state == S_E3) && !chip_acc && (DataIn == CMD_SECT);
  assign busy_start = pgm_acc || chip_acc || sect_acc;
  assign prog_done  = (state == S_BUSY_P) && (cnt == PROG_LAST);
  assign erase_done = (state == S_BUSY_E) && (cnt == erase_last);
  assign DataOut    = sel_arr ? arr_q : reg_q;

  // The program's old byte is fetched on the accepting edge; the read port
  // is then idle for the whole busy period, so arr_q still holds it at the end.
  flash_array u_array (
    .clk   (SCL),
    .we    (prog_done || (state == S_BUSY_E)),
    .waddr ((state == S_BUSY_E) ? (erase_base | cnt) : prog_addr),
    .wdata ((state == S_BUSY_E) ? 8'hFF : (arr_q & prog_data)),
    .re    ((rd && !Busy) || pgm_acc),
    .raddr (Addr),
    .rdata (arr_q)
  );

`ifndef FLASH_SOFTWARE_ID_EN
  assign id_flag = 1'b0;
`endif

  always_ff @(posedge SCL or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE; cnt <= '0; erase_base <= '0; erase_last <= '0;
      prog_addr <= '0; prog_data <= '0; pollbit <= 1'b0; toggle <= 1'b0;
      reg_q <= '0; sel_arr <= 1'b0;
`ifdef FLASH_SOFTWARE_ID_EN
      id_flag <= 1'b0;
`endif
    end else begin
      if (busy_start) toggle <= 1'b0;
      else if (rd && Busy) toggle <= ~toggle;

      if (rd) begin
        if (Busy) begin
          reg_q <= {~pollbit, toggle, 6'b0}; sel_arr <= 1'b0;
        end else if (id_flag && Addr == 16'h0000) begin
          reg_q <= MFG_ID; sel_arr <= 1'b0;
        end else if (id_flag && Addr == 16'h0001) begin
          reg_q <= DEV_ID; sel_arr <= 1'b0;
        end else sel_arr <= 1'b1;
      end else if (busy_start && sel_arr) begin
        // Freeze the last array read so DataOut holds while the read port is reused.
        reg_q <= arr_q; sel_arr <= 1'b0;
      end

      case (state)
        S_IDLE: if (WE) begin
          if (cmd_hit(Addr, DataIn, ADDR_5555, CMD_UNLOCK1)) state <= S_U1;
`ifdef FLASH_SOFTWARE_ID_EN
          else if (DataIn == CMD_EXIT) id_flag <= 1'b0;
`endif
        end
        S_U1: if (WE) state <= cmd_hit(Addr, DataIn, ADDR_AAAA, CMD_UNLOCK2) ? S_U2 : S_IDLE;
        S_U2: if (WE) begin
          state <= S_IDLE;
          if (Addr == ADDR_5555) begin
            case (DataIn)
              CMD_PROG:  state <= S_PGM;
              CMD_ERASE: state <= S_E1;
`ifdef FLASH_SOFTWARE_ID_EN
              CMD_ID:    id_flag <= 1'b1;
              CMD_EXIT:  id_flag <= 1'b0;
`endif
              default: ;
            endcase
          end
        end
        S_PGM: if (WE) begin
          prog_addr <= Addr; prog_data <= DataIn; pollbit <= DataIn[7];
          cnt <= '0; state <= S_BUSY_P;
        end
        S_E1: if (WE) state <= cmd_hit(Addr, DataIn, ADDR_5555, CMD_UNLOCK1) ? S_E2 : S_IDLE;
        S_E2: if (WE) state <= cmd_hit(Addr, DataIn, ADDR_AAAA, CMD_UNLOCK2) ? S_E3 : S_IDLE;
        S_E3: if (WE) begin
          cnt <= '0; pollbit <= 1'b1;
          if (chip_acc) begin
            erase_base <= '0; erase_last <= 16'hFFFF; state <= S_BUSY_E;
          end else if (sect_acc) begin
            erase_base <= Addr & ~SECT_MASK; erase_last <= SECT_MASK; state <= S_BUSY_E;
          end else state <= S_IDLE;
        end
        S_BUSY_P: if (prog_done) state <= S_IDLE; else cnt <= cnt + 16'd1;
        S_BUSY_E: if (erase_done) state <= S_IDLE; else cnt <= cnt + 16'd1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_responder.sv
// Directed bench for flash_cmd_responder: erase, program, polling, ID mode, abort.
module tb_flash_cmd_responder;

  logic        SCL = 1'b0, Reset = 1'b1, WE = 1'b0, RE = 1'b0;
  logic [15:0] Addr = '0;
  logic [7:0]  DataIn = '0;
  logic [7:0]  DataOut;
  logic        Busy;
  int          n_cmp = 0, n_bad = 0;

  always #5 SCL = ~SCL;

  flash_cmd_responder dut (
    .SCL(SCL), .Reset(Reset), .Addr(Addr), .DataIn(DataIn),
    .WE(WE), .RE(RE), .DataOut(DataOut), .Busy(Busy)
  );

  task automatic tick; @(posedge SCL); #1; endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    Addr = a; DataIn = d; WE = 1'b1; tick; WE = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    Addr = a; RE = 1'b1; tick; RE = 1'b0; d = DataOut;
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (Busy === 1'b1 && n < max) begin tick; n++; end
  endtask

  task automatic erase_cmd(input logic [15:0] a, input logic [7:0] d);
    wr(16'h5555, 8'hAA); wr(16'hAAAA, 8'h55); wr(16'h5555, 8'h80);
    wr(16'h5555, 8'hAA); wr(16'hAAAA, 8'h55); wr(a, d);
  endtask

  task automatic prog(input logic [15:0] a, input logic [7:0] d);
    int n;
    wr(16'h5555, 8'hAA); wr(16'hAAAA, 8'h55); wr(16'h5555, 8'hA0); wr(a, d);
    wait_idle(100, n);
    chk("prog_cycles", n, 20);
  endtask

  initial begin
    logic [7:0] d;
    int n;
    repeat (3) tick;
    chk("rst_busy", Busy, 0);
    chk("rst_dout", DataOut, 8'h00);
    Reset = 1'b0; tick;

    // chip erase
    erase_cmd(16'h5555, 8'h10);
    chk("chip_busy_rise", Busy, 1);
    wait_idle(70000, n);
    chk("chip_cycles", n, 65536);
    rd(16'h1234, d); chk("chip_1234", d, 8'hFF);

    // program with status polling
    wr(16'h5555, 8'hAA); wr(16'hAAAA, 8'h55); wr(16'h5555, 8'hA0); wr(16'h1234, 8'h3C);
    chk("prog_busy_rise", Busy, 1);
    rd(16'h1234, d); chk("poll0", d, 8'h80);
    rd(16'h1234, d); chk("poll1", d, 8'hC0);
    rd(16'h1234, d); chk("poll2", d, 8'h80);
    wait_idle(100, n);
    chk("prog_poll_cycles", n + 3, 20);
    rd(16'h1234, d); chk("prog_3c", d, 8'h3C);
    prog(16'h1234, 8'hC3);
    rd(16'h1234, d); chk("prog_and", d, 8'h00);

    // sector erase of 0x1000-0x1FFF
    prog(16'h2000, 8'h5A);
    prog(16'h1FFF, 8'h00);
    prog(16'h0FFF, 8'h00);
    erase_cmd(16'h1000, 8'h30);
    wait_idle(5000, n);
    chk("sect_cycles", n, 4096);
    rd(16'h1234, d); chk("sect_1234", d, 8'hFF);
    rd(16'h1FFF, d); chk("sect_1fff", d, 8'hFF);
    rd(16'h2000, d); chk("sect_2000", d, 8'h5A);
    rd(16'h0FFF, d); chk("sect_0fff", d, 8'h00);

    // software ID
    prog(16'h0000, 8'h12);
    wr(16'h5555, 8'hAA); wr(16'hAAAA, 8'h55); wr(16'h5555, 8'h90);
    chk("id_busy", Busy, 0);
`ifdef FLASH_SOFTWARE_ID_EN
    rd(16'h0000, d); chk("id_mfg", d, 8'hBF);
    rd(16'h0001, d); chk("id_dev", d, 8'hB5);
`else
    rd(16'h0000, d); chk("id_mfg", d, 8'h12);
    rd(16'h0001, d); chk("id_dev", d, 8'hFF);
`endif
    rd(16'h2000, d); chk("id_other", d, 8'h5A);
    wr(16'h0000, 8'hF0);
    rd(16'h0000, d); chk("id_exit", d, 8'h12);

    // broken unlock sequence
    wr(16'h5555, 8'hAA); wr(16'hAAAA, 8'h56); wr(16'h0010, 8'h3C);
    chk("broken_busy", Busy, 0);
    rd(16'h0010, d); chk("broken_0010", d, 8'hFF);

    // reset in the middle of a chip erase
    prog(16'h0005, 8'h00);
    prog(16'h0200, 8'h11);
    rd(16'h0000, d); chk("pre_abort_rd", d, 8'h12);
    erase_cmd(16'h5555, 8'h10);
    repeat (100) tick;
    chk("abort_busy_pre", Busy, 1);
    chk("abort_dout_hold", DataOut, 8'h12);
    Reset = 1'b1; #1;
    chk("abort_busy", Busy, 0);
    chk("abort_dout", DataOut, 8'h00);
    tick; Reset = 1'b0; tick;
    rd(16'h0000, d); chk("abort_0000", d, 8'hFF);
    rd(16'h0005, d); chk("abort_0005", d, 8'hFF);
    rd(16'h0200, d); chk("abort_0200", d, 8'h11);
    wr(16'h5555, 8'hAA); wr(16'hAAAA, 8'h55); wr(16'h5555, 8'hA0); wr(16'h0200, 8'h10);
    chk("post_abort_busy", Busy, 1);
    wait_idle(100, n);
    chk("post_abort_cycles", n, 20);
    rd(16'h0200, d); chk("post_abort_0200", d, 8'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
